// File: rtl/nucore_rf_pkg.sv
// nucore_rf_pkg: shared register-file constants and the port sequencer state encoding
package nucore_rf_pkg;
  localparam int N_DEF = 32;
  localparam int WIDTHBIT_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, READB = 2'd1, HOLD = 2'd2} rf_state_e;
endpackage

// File: rtl/regfile_port_seq.sv
// regfile_port_seq: serialises operand reads and writeback writes onto one register-file port
module regfile_port_seq
  import nucore_rf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int WIDTHBIT = WIDTHBIT_DEF
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                RdValid,
  output logic                RdReady,
  input  logic [WIDTHBIT-1:0] RsA,
  input  logic [WIDTHBIT-1:0] RsB,
  output logic                OpValid,
  input  logic                OpReady,
  output logic [N-1:0]        OpA,
  output logic [N-1:0]        OpB,
  input  logic                WbValid,
  output logic                WbReady,
  input  logic [WIDTHBIT-1:0] WbRd,
  input  logic [N-1:0]        WbData,
  output logic [WIDTHBIT-1:0] RfRegNo,
  output logic                RfRegWrite,
  output logic [N-1:0]        RfDin,
  input  logic [N-1:0]        RfQout
);
  rf_state_e state_q, state_d;
  logic [WIDTHBIT-1:0] rsb_q;
  logic port_free, wr_ok, rd_ok;
  always_comb begin
    port_free = state_q == IDLE || (state_q == HOLD && OpReady);
    // writes win the port; nothing is granted while the file itself is in reset
    wr_ok = Rst && WbValid && state_q != READB;
    rd_ok = Rst && RdValid && !WbValid && port_free;
    WbReady = wr_ok;
    RdReady = rd_ok;
    RfRegWrite = wr_ok;
    RfDin = wr_ok ? WbData : '0;
    RfRegNo = wr_ok ? WbRd : rd_ok ? RsA : state_q == READB ? rsb_q : '0;
    OpValid = state_q == HOLD;
    state_d = state_q == READB ? HOLD
            : rd_ok ? READB
            : (state_q == HOLD && OpReady) ? IDLE
            : state_q;
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      OpA <= '0;
      OpB <= '0;
      rsb_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_ok) begin
        OpA <= RfQout;
        rsb_q <= RsB;
      end
      if (state_q == READB) OpB <= RfQout;
    end
  end
endmodule

// File: tb/tb_regfile_port_seq.sv
// tb_regfile_port_seq: directed checks of the sequencer against a behavioural register file
module tb_regfile_port_seq;
  logic Clk = 0, Rst = 0;
  logic RdValid = 0, RdReady, OpValid, OpReady = 0, WbValid = 0, WbReady, RfRegWrite;
  logic [3:0] RsA = 0, RsB = 0, WbRd = 0, RfRegNo;
  logic [31:0] OpA, OpB, WbData = 0, RfDin, RfQout;
  logic [31:0] rf [16];
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  regfile_port_seq #(.N(32), .WIDTHBIT(4)) dut (
    .Clk(Clk), .Rst(Rst), .RdValid(RdValid), .RdReady(RdReady), .RsA(RsA), .RsB(RsB),
    .OpValid(OpValid), .OpReady(OpReady), .OpA(OpA), .OpB(OpB), .WbValid(WbValid),
    .WbReady(WbReady), .WbRd(WbRd), .WbData(WbData), .RfRegNo(RfRegNo),
    .RfRegWrite(RfRegWrite), .RfDin(RfDin), .RfQout(RfQout)
  );

  assign RfQout = rf[RfRegNo];
  always_ff @(posedge Clk) begin
    if (!Rst) for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (RfRegWrite) rf[RfRegNo] <= RfDin;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tick(); tick();
    chk("rst_opvalid", {31'd0, OpValid}, 32'd0);
    chk("rst_opa", OpA, 32'd0);
    chk("rst_opb", OpB, 32'd0);
    WbValid = 1; RdValid = 1; #1;
    chk("rst_wbready", {31'd0, WbReady}, 32'd0);
    chk("rst_rdready", {31'd0, RdReady}, 32'd0);
    chk("rst_regwrite", {31'd0, RfRegWrite}, 32'd0);
    RdValid = 0;
    Rst = 1; WbRd = 3; WbData = 32'h11; #1;
    chk("wb_ready", {31'd0, WbReady}, 32'd1);
    chk("wb_regno", {28'd0, RfRegNo}, 32'd3);
    chk("wb_din", RfDin, 32'h11);
    tick();
    WbRd = 5; WbData = 32'h22;
    tick();
    WbValid = 0; RdValid = 1; RsA = 3; RsB = 5; #1;
    chk("rd_ready", {31'd0, RdReady}, 32'd1);
    chk("rd_regno_a", {28'd0, RfRegNo}, 32'd3);
    chk("idle_din", RfDin, 32'd0);
    tick();
    RdValid = 0; #1;
    chk("readb_opvalid", {31'd0, OpValid}, 32'd0);
    chk("readb_regno", {28'd0, RfRegNo}, 32'd5);
    tick();
    chk("rd_opvalid", {31'd0, OpValid}, 32'd1);
    chk("rd_opa", OpA, 32'h11);
    chk("rd_opb", OpB, 32'h22);
    OpReady = 1;
    tick();
    chk("hs_opvalid", {31'd0, OpValid}, 32'd0);
    OpReady = 0;
    WbValid = 1; WbRd = 4; WbData = 32'hAB; RdValid = 1; RsA = 4; RsB = 4; #1;
    chk("sim_wbready", {31'd0, WbReady}, 32'd1);
    chk("sim_rdready", {31'd0, RdReady}, 32'd0);
    tick();
    WbValid = 0; #1;
    chk("sim_rdready2", {31'd0, RdReady}, 32'd1);
    tick();
    RdValid = 0;
    tick();
    chk("sim_opvalid", {31'd0, OpValid}, 32'd1);
    chk("sim_opa", OpA, 32'hAB);
    chk("sim_opb", OpB, 32'hAB);
    WbValid = 1; WbRd = 3; WbData = 32'hFF; #1;
    chk("stall_wbready", {31'd0, WbReady}, 32'd1);
    tick();
    WbValid = 0; RdValid = 1; RsA = 3; RsB = 3; #1;
    chk("stall_rdready", {31'd0, RdReady}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("stall_opvalid", {31'd0, OpValid}, 32'd1);
    chk("stall_opa", OpA, 32'hAB);
    chk("stall_opb", OpB, 32'hAB);
    OpReady = 1; #1;
    chk("hs_accept_rdready", {31'd0, RdReady}, 32'd1);
    tick();
    RdValid = 0;
    chk("hs_accept_readb", {31'd0, OpValid}, 32'd0);
    tick();
    chk("r3_opa", OpA, 32'hFF);
    chk("r3_opb", OpB, 32'hFF);
    WbValid = 1; WbRd = 1; WbData = 32'hA1;
    tick();
    WbRd = 2; WbData = 32'hA2;
    tick();
    WbRd = 6; WbData = 32'hA6;
    tick();
    WbRd = 7; WbData = 32'hA7;
    tick();
    WbValid = 0; RdValid = 1; RsA = 1; RsB = 2;
    tick();
    RsA = 6; RsB = 7; #1;
    chk("b2b_readb_rdready", {31'd0, RdReady}, 32'd0);
    tick();
    chk("b2b_p1_valid", {31'd0, OpValid}, 32'd1);
    chk("b2b_p1_opa", OpA, 32'hA1);
    chk("b2b_p1_opb", OpB, 32'hA2);
    chk("b2b_p1_rdready", {31'd0, RdReady}, 32'd1);
    tick();
    RdValid = 0;
    chk("b2b_readb2", {31'd0, OpValid}, 32'd0);
    tick();
    chk("b2b_p2_valid", {31'd0, OpValid}, 32'd1);
    chk("b2b_p2_opa", OpA, 32'hA6);
    chk("b2b_p2_opb", OpB, 32'hA7);
    tick();
    chk("b2b_idle", {31'd0, OpValid}, 32'd0);
    RdValid = 1; RsA = 1; RsB = 2;
    tick();
    RdValid = 0; WbValid = 1; WbRd = 9; WbData = 32'h99; #1;
    chk("readb_wbready", {31'd0, WbReady}, 32'd0);
    chk("readb_regwrite", {31'd0, RfRegWrite}, 32'd0);
    tick();
    chk("postreadb_wbready", {31'd0, WbReady}, 32'd1);
    chk("postreadb_regwrite", {31'd0, RfRegWrite}, 32'd1);
    chk("postreadb_opb", OpB, 32'hA2);
    tick();
    WbValid = 0; RdValid = 1; RsA = 9; RsB = 1; #1;
    chk("r9_written", RfQout, 32'h99);
    tick();
    RdValid = 0; WbValid = 1; Rst = 0; #1;
    chk("rstb_regwrite", {31'd0, RfRegWrite}, 32'd0);
    chk("rstb_wbready", {31'd0, WbReady}, 32'd0);
    tick();
    chk("rstb_opvalid", {31'd0, OpValid}, 32'd0);
    chk("rstb_opa", OpA, 32'd0);
    chk("rstb_opb", OpB, 32'd0);
    Rst = 1; WbValid = 0; RdValid = 1; #1;
    chk("rstb_idle_rdready", {31'd0, RdReady}, 32'd1);
    tick();
    RdValid = 0;
    tick();
    chk("rstb_rd_valid", {31'd0, OpValid}, 32'd1);
    chk("rstb_rd_opa", OpA, 32'd0);
    chk("rstb_rd_opb", OpB, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
